serial_frame_receiver: RTL
==========================

Name: serial_frame_receiver

Overview:
- Receive side of the board-to-board serial link: deserializes a fixed-length frame from the partner board's serial clock and data lines into a parallel receive buffer.
- Drives the ready-for-receive handshake line back to the sender.
- Sits between the GPIO input pins and the HEX/LED display logic in the top level.
- The partner's serial clock is asynchronous to clk, so it is oversampled, not used as a clock.

Parameters:
- FRAME_BITS, 256, bits per frame; also the width of receive_buffer.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).
- TIMEOUT_CYCLES, 1023, clk cycles without a serial-clock rising edge before a partial frame is aborted.

Ports:
- clk  input  1  system clock (divided CLOCK_50).
- rst  input  1  synchronous, active-high reset.
- enable  input  1  permits arming for a new frame.
- clk_in  input  1  serial clock from the sender; asynchronous.
- data_in  input  1  serial data from the sender; sampled on the clk_in rising edge.
- ready_for_receive  output  1  high while armed and while a frame is in progress.
- receive_buffer  output  FRAME_BITS  last completed frame; bit FRAME_BITS-1 holds the first bit received.
- frame_valid  output  1  one-cycle pulse when receive_buffer updates.
- frame_error  output  1  one-cycle pulse when a partial frame is aborted.
- busy  output  1  high in the RECV state.

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; ready_for_receive=0; receive_buffer=0; frame_valid=0; frame_error=0; busy=0; bit counter=0; timeout counter=0; synchronizer flops=0.
- Input conditioning:
  - clk_in and data_in each pass through SYNC_STAGES flops.
  - sedge = synced clk_in is 1 this cycle and was 0 the previous cycle.
  - Data is taken from the synced data_in in the same cycle sedge is high.
  - Sender requirement: each clk_in high and low phase lasts at least SYNC_STAGES+1 clk cycles, and data_in is stable across each rising edge.
- States:
  - IDLE: ready_for_receive=0. Go to READY when enable=1.
  - READY: ready_for_receive=1. The first sedge shifts in bit 0 of the frame, sets bit count to 1, clears the timeout counter, and moves to RECV. enable=0 with no sedge returns to IDLE.
  - RECV: ready_for_receive=1, busy=1.
    - Each sedge shifts the sample into a shadow shift register (MSB-first, left shift), increments the bit count, and clears the timeout counter.
    - Cycles with no sedge increment the timeout counter.
    - When bit count reaches FRAME_BITS (on the sedge that delivers the last bit), go to DONE.
    - When the timeout counter reaches TIMEOUT_CYCLES, raise frame_error for one cycle, discard the shadow register, leave receive_buffer unchanged, and go to IDLE.
    - enable is ignored in RECV; an in-progress frame always completes or times out.
  - DONE (one cycle): copy the shadow register to receive_buffer atomically and pulse frame_valid. ready_for_receive=0 in this cycle. Next state is READY if enable=1, else IDLE.
- Latency: frame_valid and receive_buffer update exactly one clk after the cycle in which the final sedge is detected. That sedge is SYNC_STAGES+1 clk after the pin edge.
- receive_buffer never shows a partial frame. It holds its value across IDLE, READY and aborted frames.
- A sedge in the DONE or IDLE cycle is ignored and not counted.
- rst asserted mid-frame returns everything to reset values on the next clk edge. Clearing receive_buffer on reset is intended.
- The timeout counter is log2(TIMEOUT_CYCLES+1) bits wide and saturating. The bit counter is log2(FRAME_BITS)+1 bits wide.

Decomposition:
- Shared package (comms_pkg):
  - State enum: IDLE, READY, RECV, DONE.
  - Default FRAME_BITS and TIMEOUT_CYCLES constants, shared with the transmit side so both ends agree on the frame length.
- Sub-module sync_edge_detect (parameter SYNC_STAGES):
  - Inputs: clk, rst, async_in.
  - Outputs: sync_out, rise_pulse.
  - Instantiated once for clk_in and once, with rise_pulse unused, for data_in.

Test Plan:
- Reset and arm: hold rst 3 cycles then enable=1 → all outputs 0 during reset; ready_for_receive=1 two cycles after rst falls; receive_buffer=0.
- Full frame: send 256 bits with bit255=1, bit0=1, rest 0, each clk_in phase 4 clk → frame_valid pulses once, receive_buffer=(1<<255)+1, busy drops, ready_for_receive=0 for exactly 1 cycle and then returns to 1.
- Alternating frame: send pattern 0xAAAA...AA, then a second frame 0x5555...55 back-to-back → two frame_valid pulses with the matching buffer values; no frame_error.
- Timeout: send 100 bits, then hold clk_in low for 1100 cycles → frame_error pulses after 1023 idle cycles; receive_buffer keeps the previous frame; state returns to READY with enable=1.
- Disable mid-frame: drop enable after bit 50 and continue to bit 256 → frame completes and frame_valid pulses; then ready_for_receive=0 and the state stays IDLE.
- Reset mid-frame: assert rst after bit 128 → receive_buffer=0, no frame_valid; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/comms_pkg.sv
// Shared definitions for the board-to-board serial link, used by both the
// transmit and receive ends so they agree on frame length and timing.
package comms_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    localparam int FRAME_BITS_DEFAULT     = 256;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1023;

endpackage

// File: rtl/serial_frame_receiver_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input with a rising-edge
// detector on the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_out   = sync_reg[SYNC_STAGES-1];
    assign rise_pulse = sync_out & ~prev_reg;

endmodule

// File: rtl/serial_frame_receiver.sv
// Receive side of the serial link: oversamples the partner's serial clock and
// data, assembles a fixed-length MSB-first frame, and publishes it atomically.
module serial_frame_receiver
    import comms_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clk_in,
    input  logic                  data_in,
    output logic                  ready_for_receive,
    output logic [FRAME_BITS-1:0] receive_buffer,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic sedge;
    logic clk_level_unused;
    logic data_sync;
    logic data_rise_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (clk_in),
        .sync_out   (clk_level_unused),
        .rise_pulse (sedge)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (data_in),
        .sync_out   (data_sync),
        .rise_pulse (data_rise_unused)
    );

    rx_state_t             state_reg;
    rx_state_t             state_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_next;
    logic [FRAME_BITS-1:0] buffer_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [TO_W-1:0]       timeout_reg;
    logic                  last_bit;
    logic                  timed_out;
    logic                  shift_en;
    logic                  complete;

    assign last_bit  = (bit_cnt_reg == CNT_W'(FRAME_BITS - 1));
    assign timed_out = (timeout_reg == TO_W'(TIMEOUT_CYCLES));
    // A timeout wins over a coincident edge so an aborted frame never publishes.
    assign shift_en  = sedge && ((state_reg == READY) || ((state_reg == RECV) && !timed_out));
    assign complete  = shift_en && last_bit;

    // The first bit of a frame starts from a cleared shadow so stale data never leaks in.
    assign shift_next = (state_reg == READY) ? FRAME_BITS'(data_sync)
                                             : ((shift_reg << 1) | FRAME_BITS'(data_sync));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = READY;
            end
            READY: begin
                if (sedge)        state_next = last_bit ? DONE : RECV;
                else if (!enable) state_next = IDLE;
            end
            RECV: begin
                if (timed_out)     state_next = IDLE;
                else if (complete) state_next = DONE;
            end
            DONE: begin
                state_next = enable ? READY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_for_receive = 1'b0;
        busy              = 1'b0;
        frame_valid       = 1'b0;
        frame_error       = 1'b0;
        case (state_reg)
            READY: ready_for_receive = 1'b1;
            RECV: begin
                ready_for_receive = 1'b1;
                busy              = 1'b1;
                frame_error       = timed_out;
            end
            DONE:    frame_valid = 1'b1;
            default: ;
        endcase
    end

    // The buffer is loaded on the final edge so it is already stable while frame_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            buffer_reg  <= '0;
            bit_cnt_reg <= '0;
            timeout_reg <= '0;
        end else begin
            if (shift_en) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                timeout_reg <= '0;
            end else if (state_reg == RECV) begin
                if (!timed_out) timeout_reg <= timeout_reg + TO_W'(1);
            end else begin
                bit_cnt_reg <= '0;
                timeout_reg <= '0;
            end
            if (complete) buffer_reg <= shift_next;
        end
    end

    assign receive_buffer = buffer_reg;

endmodule
